// File: rtl/row_window_buffer.sv
// Row window buffer: stacks three consecutive image rows of 8-lane 1x3 windows
// into 8-lane 3x3 windows using two line memories (row r-2 in A, row r-1 in B).
module row_window_buffer #(
  parameter int BEATS_PER_ROW = 16,
  parameter int CNT_W         = 4
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         in_valid,
  input  logic         in_sof,
  input  logic [7:0]   in_mask,
  input  logic [191:0] in_map,
  output logic         out_valid,
  output logic         out_last,
  output logic [7:0]   out_mask,
  output logic [575:0] out_win
);
  localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(BEATS_PER_ROW - 1);

  // Each entry is {lane mask, 8 lanes x 24-bit pixels}
  logic [199:0]     r_memA [BEATS_PER_ROW];
  logic [199:0]     r_memB [BEATS_PER_ROW];
  logic [CNT_W-1:0] r_colCnt;
  logic [1:0]       r_rowCnt;

  logic [CNT_W-1:0] w_col;
  logic [1:0]       w_row;
  logic             w_lastCol;
  logic             w_full;
  logic [199:0]     w_rdA;
  logic [199:0]     w_rdB;
  logic [575:0]     w_win;

  // A start-of-frame beat overrides the running position
  assign w_col     = in_sof ? '0 : r_colCnt;
  assign w_row     = in_sof ? 2'd0 : r_rowCnt;
  assign w_lastCol = (w_col == LAST_COL);
  assign w_full    = (w_row == 2'd2);
  assign w_rdA     = r_memA[w_col];
  assign w_rdB     = r_memB[w_col];

  always_comb begin
    w_win = '0;
    for (int i = 0; i < 8; i++) begin
      w_win[72*i +: 72] = {in_map[24*i +: 24], w_rdB[24*i +: 24], w_rdA[24*i +: 24]};
    end
  end

  // Line memories shift down one row per accepted beat; reads above see old contents
  always_ff @(posedge clk) begin
    if (in_valid) begin
      r_memA[w_col] <= w_rdB;
      r_memB[w_col] <= {in_mask, in_map};
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_mask  <= '0;
      out_win   <= '0;
      r_colCnt  <= '0;
      r_rowCnt  <= 2'd0;
    end else if (in_valid) begin
      out_valid <= w_full;
      out_last  <= w_lastCol && w_full;
      out_mask  <= in_mask & w_rdB[199:192] & w_rdA[199:192];
      out_win   <= w_win;
      if (w_lastCol) begin
        r_colCnt <= '0;
        r_rowCnt <= w_full ? 2'd2 : w_row + 2'd1;
      end else begin
        r_colCnt <= w_col + CNT_W'(1);
        r_rowCnt <= w_row;
      end
    end else begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_row_window_buffer.sv
// Testbench for row_window_buffer: random beats checked against a model that keeps
// every beat since the frame start and builds each window from beats k, k-16, k-32.
module tb_row_window_buffer;
  localparam int BPR = 16;

  logic         clk;
  logic         nrst;
  logic         inValid;
  logic         inSof;
  logic [7:0]   inMask;
  logic [191:0] inMap;
  logic         outValid;
  logic         outLast;
  logic [7:0]   outMask;
  logic [575:0] outWin;

  int errors = 0;
  int checks = 0;

  // Model state: all beats since the last frame start / reset
  logic [199:0] hist[$];
  logic         expValid;
  logic         expLast;
  logic [7:0]   expMask;
  logic [575:0] expWin;
  bit           expKnown;

  row_window_buffer #(.BEATS_PER_ROW(BPR), .CNT_W(4)) dut (
    .clk(clk), .nrst(nrst), .in_valid(inValid), .in_sof(inSof),
    .in_mask(inMask), .in_map(inMap), .out_valid(outValid), .out_last(outLast),
    .out_mask(outMask), .out_win(outWin)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [191:0] randMap();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [191:0] rampMap(input int row, input int col);
    logic [7:0] b;
    b = 8'(row * 16 + col);
    return {24{b}};
  endfunction

  // Drive one cycle and advance the model; outputs are sampled 1 time unit after the edge
  task automatic applyStimulus(input bit v, input bit sof, input logic [7:0] m,
                               input logic [191:0] map);
    int k;
    int row;
    int col;
    logic [199:0] top;
    logic [199:0] mid;
    @(negedge clk);
    inValid = v;
    inSof   = sof;
    inMask  = m;
    inMap   = map;
    if (v) begin
      if (sof) hist.delete();
      hist.push_back({m, map});
      k   = hist.size() - 1;
      row = k / BPR;
      col = k % BPR;
      expValid = (row >= 2);
      expLast  = expValid && (col == BPR - 1);
      if (expValid) begin
        top = hist[k - 2*BPR];
        mid = hist[k - BPR];
        expMask = m & mid[199:192] & top[199:192];
        for (int i = 0; i < 8; i++)
          expWin[72*i +: 72] = {map[24*i +: 24], mid[24*i +: 24], top[24*i +: 24]};
        expKnown = 1'b1;
      end else begin
        expKnown = 1'b0;
      end
    end else begin
      expValid = 1'b0;
      expLast  = 1'b0;
    end
    @(posedge clk);
    #1;
    inValid = 1'b0;
    inSof   = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clk);
    nrst    = 1'b0;
    inValid = 1'b0;
    inSof   = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    hist.delete();
    expValid = 1'b0;
    expLast  = 1'b0;
    expMask  = '0;
    expWin   = '0;
    expKnown = 1'b1;
  endtask

  task automatic test_reset();
    nrst = 1'b0; inValid = 1'b0; inSof = 1'b0; inMask = '0; inMap = '0;
    #3;
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL reset valid: got %b want 0", outValid); end
    checks++; if (outLast !== 1'b0) begin errors++; $display("FAIL reset last: got %b want 0", outLast); end
    checks++; if (outMask !== 8'h00) begin errors++; $display("FAIL reset mask: got %h want 00", outMask); end
    checks++; if (outWin !== '0) begin errors++; $display("FAIL reset win: got %h want 0", outWin); end
    doReset();
  endtask

  task automatic test_full_rows();
    int nValid = 0;
    int nLast = 0;
    doReset();
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < BPR; c++) begin
        applyStimulus(1'b1, (r == 0 && c == 0), 8'hFF, rampMap(r, c));
        if (outValid === 1'b1) nValid++;
        if (outLast === 1'b1) nLast++;
        checks++; if (outValid !== expValid) begin errors++; $display("FAIL full valid r%0d c%0d: got %b want %b", r, c, outValid, expValid); end
        checks++; if (outLast !== expLast) begin errors++; $display("FAIL full last r%0d c%0d: got %b want %b", r, c, outLast, expLast); end
        if (expKnown) begin
          checks++; if (outWin !== expWin) begin errors++; $display("FAIL full win r%0d c%0d: got %h want %h", r, c, outWin, expWin); end
          checks++; if (outMask !== expMask) begin errors++; $display("FAIL full mask r%0d c%0d: got %h want %h", r, c, outMask, expMask); end
        end
        if (r == 2 && c == 5) begin
          checks++;
          if (outWin[72*3 +: 72] !== 72'h252525_151515_050505) begin
            errors++; $display("FAIL full lane3 r2c5: got %h want 252525151515050505", outWin[72*3 +: 72]);
          end
        end
      end
    end
    checks++; if (nValid != 16) begin errors++; $display("FAIL full valid count: got %0d want 16", nValid); end
    checks++; if (nLast != 1) begin errors++; $display("FAIL full last count: got %0d want 1", nLast); end
  endtask

  task automatic test_gaps();
    doReset();
    for (int n = 0; n < 3*BPR; n++) begin
      applyStimulus(1'b1, (n == 0), 8'($urandom), randMap());
      checks++; if (outValid !== expValid) begin errors++; $display("FAIL gaps valid beat %0d: got %b want %b", n, outValid, expValid); end
      checks++; if (outLast !== expLast) begin errors++; $display("FAIL gaps last beat %0d: got %b want %b", n, outLast, expLast); end
      if (expKnown) begin
        checks++; if (outWin !== expWin) begin errors++; $display("FAIL gaps win beat %0d: got %h want %h", n, outWin, expWin); end
      end
      applyStimulus(1'b0, 1'b0, 8'($urandom), randMap());
      checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL gaps idle valid beat %0d: got %b want 0", n, outValid); end
      if (expKnown) begin
        checks++; if (outWin !== expWin) begin errors++; $display("FAIL gaps held win beat %0d: got %h want %h", n, outWin, expWin); end
        checks++; if (outMask !== expMask) begin errors++; $display("FAIL gaps held mask beat %0d: got %h want %h", n, outMask, expMask); end
      end
    end
  endtask

  task automatic test_mask();
    doReset();
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < BPR; c++) begin
        applyStimulus(1'b1, (r == 0 && c == 0), (r == 0 && c == 0) ? 8'hFC : 8'hFF, randMap());
        if (expKnown) begin
          checks++; if (outMask !== expMask) begin errors++; $display("FAIL mask r%0d c%0d: got %h want %h", r, c, outMask, expMask); end
        end
        if (r == 2 && c == 0) begin
          checks++; if (outMask !== 8'hFC) begin errors++; $display("FAIL mask r2c0 inherited: got %h want FC", outMask); end
        end
        if (r == 3 && c == 0) begin
          checks++; if (outMask !== 8'hFF) begin errors++; $display("FAIL mask r3c0 aged: got %h want FF", outMask); end
        end
      end
    end
  endtask

  task automatic test_sof_midrow();
    int nValid = 0;
    doReset();
    for (int n = 0; n < 40; n++) applyStimulus(1'b1, 1'b0, 8'($urandom), randMap());
    // A lone sof without valid must be ignored
    applyStimulus(1'b0, 1'b1, 8'hFF, randMap());
    for (int n = 0; n < 3*BPR; n++) begin
      applyStimulus(1'b1, (n == 0), 8'($urandom), randMap());
      if (outValid === 1'b1) nValid++;
      checks++; if (outValid !== expValid) begin errors++; $display("FAIL sof valid beat %0d: got %b want %b", n, outValid, expValid); end
      checks++; if (outLast !== expLast) begin errors++; $display("FAIL sof last beat %0d: got %b want %b", n, outLast, expLast); end
      if (expKnown) begin
        checks++; if (outWin !== expWin) begin errors++; $display("FAIL sof win beat %0d: got %h want %h", n, outWin, expWin); end
        checks++; if (outMask !== expMask) begin errors++; $display("FAIL sof mask beat %0d: got %h want %h", n, outMask, expMask); end
      end
    end
    checks++; if (nValid != 16) begin errors++; $display("FAIL sof valid count: got %0d want 16", nValid); end
  endtask

  task automatic test_reset_midframe();
    int firstValid = -1;
    doReset();
    for (int n = 0; n < 2*BPR + 7; n++) applyStimulus(1'b1, (n == 0), 8'hFF, randMap());
    @(negedge clk);
    inValid = 1'b1; inMap = randMap(); inMask = 8'hFF;
    #2;
    nrst = 1'b0;
    #1;
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL midreset valid: got %b want 0", outValid); end
    checks++; if (outMask !== 8'h00) begin errors++; $display("FAIL midreset mask: got %h want 00", outMask); end
    checks++; if (outWin !== '0) begin errors++; $display("FAIL midreset win: got %h want 0", outWin); end
    inValid = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    hist.delete();
    expMask = '0; expWin = '0; expKnown = 1'b1;
    for (int n = 1; n <= 3*BPR; n++) begin
      applyStimulus(1'b1, 1'b0, 8'($urandom), randMap());
      if (outValid === 1'b1 && firstValid < 0) firstValid = n;
      checks++; if (outValid !== expValid) begin errors++; $display("FAIL midreset stream valid beat %0d: got %b want %b", n, outValid, expValid); end
      if (expKnown) begin
        checks++; if (outWin !== expWin) begin errors++; $display("FAIL midreset stream win beat %0d: got %h want %h", n, outWin, expWin); end
      end
    end
    checks++; if (firstValid != 33) begin errors++; $display("FAIL midreset first valid: got %0d want 33", firstValid); end
  endtask

  task automatic test_back_to_back();
    int nValid = 0;
    doReset();
    for (int n = 0; n < 5*BPR; n++) begin
      applyStimulus(1'b1, (n == 0), 8'($urandom), randMap());
      if (outValid === 1'b1) nValid++;
      checks++; if (outValid !== expValid) begin errors++; $display("FAIL b2b valid beat %0d: got %b want %b", n, outValid, expValid); end
      checks++; if (outLast !== expLast) begin errors++; $display("FAIL b2b last beat %0d: got %b want %b", n, outLast, expLast); end
      if (expKnown) begin
        checks++; if (outWin !== expWin) begin errors++; $display("FAIL b2b win beat %0d: got %h want %h", n, outWin, expWin); end
        checks++; if (outMask !== expMask) begin errors++; $display("FAIL b2b mask beat %0d: got %h want %h", n, outMask, expMask); end
      end
    end
    checks++; if (nValid != 48) begin errors++; $display("FAIL b2b valid count: got %0d want 48", nValid); end
  endtask

  initial begin
    test_reset();
    test_full_rows();
    test_gaps();
    test_mask();
    test_sof_midrow();
    test_reset_midframe();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
